// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the completer (and by the master that drives
// it): transfer state encoding, default bus widths and the ID register value.
// ----------------------------------------------------------------------------
package apb_pkg;

    // Completer transfer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_t;

    // Default bus widths shared with the APB master
    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;

    // Constant returned by reads of address 0
    localparam logic [7:0] APB_ID_VALUE = 8'hA5;

endpackage : apb_pkg

// File: rtl/apb_regfile_mem.sv
// ----------------------------------------------------------------------------
// apb_regfile_mem
// DEPTH x DATA_W register storage: synchronous write, asynchronous read,
// asynchronous clear. Out-of-range addresses write nothing and read zero.
//
// Ports:
//   i_clk    - write clock
//   i_rst_n  - async active-low clear of every location
//   i_we     - write enable (sampled on rising i_clk)
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address (combinational read)
//   o_rdata  - read data
// ----------------------------------------------------------------------------
module apb_regfile_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_in_range;
    logic              w_rd_in_range;

    assign w_wr_in_range = ({1'b0, i_waddr} < DEPTH_L);
    assign w_rd_in_range = ({1'b0, i_raddr} < DEPTH_L);

    // Storage array: async clear, write on rising clock when enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we && w_wr_in_range) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_in_range ? r_mem[i_raddr] : {DATA_W{1'b0}};

endmodule : apb_regfile_mem

// File: rtl/apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile
// APB completer with a byte-wide register file, read-only ID at address 0,
// out-of-range error response and WAIT_CYCLES programmable wait states.
// All outputs are registered; the request is latched in the setup phase.
//
// Ports:
//   pclk     - clock
//   presetn  - async active-low reset
//   psel     - completer select
//   penable  - access phase indicator
//   paddr    - transfer address
//   pwrite   - 1 = write, 0 = read
//   pwdata   - write data
//   prdata   - read data (valid while pready=1 on a read)
//   pready   - transfer completes at the edge where psel&penable&pready
//   pslverr  - error response (valid while pready=1)
// ----------------------------------------------------------------------------
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                DEPTH       = 12,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(APB_ID_VALUE)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    apb_state_t        r_state;
    apb_state_t        w_state_nxt;
    logic [3:0]        r_cnt,    w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
    logic              r_write,  w_write_nxt;
    logic              r_pready, w_pready_nxt;
    logic              r_pslverr, w_pslverr_nxt;
    logic [DATA_W-1:0] r_prdata, w_prdata_nxt;
    logic              w_we;

    // Response decode source: live bus in IDLE (zero-wait completion
    // registers its response at the setup edge), latched request otherwise
    logic [ADDR_W-1:0] w_rsp_addr;
    logic              w_rsp_write;
    logic              w_rsp_oor;
    logic              w_rsp_id;
    logic              w_rsp_err;
    logic [DATA_W-1:0] w_rsp_data;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_rsp_addr  = (r_state == ST_IDLE) ? paddr  : r_addr;
    assign w_rsp_write = (r_state == ST_IDLE) ? pwrite : r_write;
    assign w_rsp_oor   = ({1'b0, w_rsp_addr} >= DEPTH_L);
    assign w_rsp_id    = (w_rsp_addr == {ADDR_W{1'b0}});
    assign w_rsp_err   = w_rsp_oor || (w_rsp_write && w_rsp_id);

    // Write responses and out-of-range reads return zero
    assign w_rsp_data  = (w_rsp_write || w_rsp_oor) ? {DATA_W{1'b0}} :
                         w_rsp_id                   ? ID_VALUE       :
                                                      w_mem_rdata;

    apb_regfile_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (w_rsp_addr),
        .o_rdata (w_mem_rdata)
    );

    // Next-state, latch, response and write-enable decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_write_nxt   = r_write;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = {DATA_W{1'b0}};
        w_we          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A stray penable without a setup phase is not a transfer
                if (psel && !penable) begin
                    w_addr_nxt  = paddr;
                    w_wdata_nxt = pwdata;
                    w_write_nxt = pwrite;
                    w_cnt_nxt   = WAIT_L;
                    if (WAIT_L == 4'd0) begin
                        w_state_nxt   = ST_DONE;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_rsp_err;
                        w_prdata_nxt  = w_rsp_data;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt   = ST_DONE;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_rsp_err;
                        w_prdata_nxt  = w_rsp_data;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable) begin
                    w_we        = r_write && !w_rsp_err;
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Hold the response until the access phase arrives
                    w_pready_nxt  = r_pready;
                    w_pslverr_nxt = r_pslverr;
                    w_prdata_nxt  = r_prdata;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DATA_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_write   <= w_write_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Directed bench for apb_slave_regfile: one instance with two wait states
// (u_w2) and one with zero wait states (u_w0), sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_apb_slave_regfile;

    logic       pclk;
    logic       presetn;

    logic       psel2, penable2, pwrite2, pready2, pslverr2;
    logic [3:0] paddr2;
    logic [7:0] pwdata2, prdata2;

    logic       psel0, penable0, pwrite0, pready0, pslverr0;
    logic [3:0] paddr0;
    logic [7:0] pwdata0, prdata0;

    int total = 0;
    int bad   = 0;

    apb_slave_regfile #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_CYCLES(2),
                        .ID_VALUE(8'hA5)) u_w2 (
        .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable2),
        .paddr(paddr2), .pwrite(pwrite2), .pwdata(pwdata2),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    apb_slave_regfile #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_CYCLES(0),
                        .ID_VALUE(8'hA5)) u_w0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable0),
        .paddr(paddr0), .pwrite(pwrite0), .pwdata(pwdata0),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic drive(input int inst, input logic s, input logic e,
                         input logic [3:0] a, input logic w, input logic [7:0] d);
        if (inst == 0) begin
            psel0 = s; penable0 = e; paddr0 = a; pwrite0 = w; pwdata0 = d;
        end else begin
            psel2 = s; penable2 = e; paddr2 = a; pwrite2 = w; pwdata2 = d;
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? pready0 : pready2;
    endfunction

    // One APB transfer; leaves psel/penable high so a following call is
    // back-to-back. cyc = access cycles until pready seen (99 on timeout).
    task automatic xfer(input int inst, input logic [3:0] a, input logic w,
                        input logic [7:0] d, output logic [7:0] rd,
                        output logic err, output int cyc, output logic rdy_setup);
        @(negedge pclk);
        drive(inst, 1'b1, 1'b0, a, w, d);
        rdy_setup = rdy(inst);
        @(negedge pclk);
        drive(inst, 1'b1, 1'b1, a, w, d);
        cyc = 1;
        while (!rdy(inst) && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        if (!rdy(inst)) cyc = 99;
        rd  = (inst == 0) ? prdata0  : prdata2;
        err = (inst == 0) ? pslverr0 : pslverr2;
    endtask

    task automatic idle(input int inst);
        @(negedge pclk);
        drive(inst, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        total++; if (pready2 !== 1'b0) begin bad++; $display("FAIL reset_pready2 got=%b exp=0", pready2); end
        total++; if (pslverr2 !== 1'b0) begin bad++; $display("FAIL reset_pslverr2 got=%b exp=0", pslverr2); end
        total++; if (prdata2 !== 8'h00) begin bad++; $display("FAIL reset_prdata2 got=%h exp=00", prdata2); end
        total++; if (pready0 !== 1'b0) begin bad++; $display("FAIL reset_pready0 got=%b exp=0", pready0); end
    endtask

    task automatic test_rw_wait2;
        logic [7:0] rd; logic err, rs; int cyc;
        xfer(2, 4'd5, 1'b1, 8'h3C, rd, err, cyc, rs);
        total++; if (cyc !== 3) begin bad++; $display("FAIL w2_wr_cycles got=%0d exp=3", cyc); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL w2_wr_err got=%b exp=0", err); end
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL w2_wr_prdata got=%h exp=00", rd); end
        idle(2);
        total++; if (pready2 !== 1'b0) begin bad++; $display("FAIL w2_pready_one_cycle got=%b exp=0", pready2); end
        xfer(2, 4'd5, 1'b0, 8'h00, rd, err, cyc, rs);
        total++; if (cyc !== 3) begin bad++; $display("FAIL w2_rd_cycles got=%0d exp=3", cyc); end
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL w2_rd_data got=%h exp=3c", rd); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL w2_rd_err got=%b exp=0", err); end
        idle(2);
    endtask

    task automatic test_id;
        logic [7:0] rd; logic err, rs; int cyc;
        xfer(2, 4'd0, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (rd !== 8'hA5 || err !== 1'b0) begin bad++; $display("FAIL id_read got=%h/%b exp=a5/0", rd, err); end
        xfer(2, 4'd0, 1'b1, 8'hFF, rd, err, cyc, rs); idle(2);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL id_write_err got=%b exp=1", err); end
        xfer(2, 4'd0, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (rd !== 8'hA5) begin bad++; $display("FAIL id_reread got=%h exp=a5", rd); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] rd; logic err, rs; int cyc;
        logic [7:0] exp_mem [12];
        for (int i = 0; i < 12; i++) exp_mem[i] = 8'h00;
        exp_mem[5] = 8'h3C;
        xfer(2, 4'd13, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (err !== 1'b1 || rd !== 8'h00) begin bad++; $display("FAIL oor_read got=%h/%b exp=00/1", rd, err); end
        xfer(2, 4'd14, 1'b1, 8'h77, rd, err, cyc, rs); idle(2);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b exp=1", err); end
        for (int a = 1; a < 12; a++) begin
            xfer(2, 4'(a), 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
            total++; if (rd !== exp_mem[a]) begin bad++; $display("FAIL oor_scan_%0d got=%h exp=%h", a, rd, exp_mem[a]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rd; logic err, rs; int cyc;
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            xfer(0, 4'(i + 1), 1'b1, vals[i], rd, err, cyc, rs);
            total++; if (cyc !== 1 || rs !== 1'b0) begin bad++; $display("FAIL b2b_wr_%0d cyc=%0d rdy_setup=%b exp=1/0", i, cyc, rs); end
        end
        for (int i = 0; i < 3; i++) begin
            xfer(0, 4'(i + 1), 1'b0, 8'h00, rd, err, cyc, rs);
            total++; if (cyc !== 1 || rs !== 1'b0) begin bad++; $display("FAIL b2b_rd_%0d cyc=%0d rdy_setup=%b exp=1/0", i, cyc, rs); end
            total++; if (rd !== vals[i] || err !== 1'b0) begin bad++; $display("FAIL b2b_data_%0d got=%h/%b exp=%h/0", i, rd, err, vals[i]); end
        end
        idle(0);
    endtask

    task automatic test_abort;
        logic [7:0] rd; logic err, rs; int cyc; int seen;
        @(negedge pclk); drive(2, 1'b1, 1'b0, 4'd4, 1'b1, 8'h99);
        @(negedge pclk); drive(2, 1'b1, 1'b1, 4'd4, 1'b1, 8'h99);
        seen = 0;
        @(negedge pclk); if (pready2) seen++;
        drive(2, 1'b0, 1'b0, 4'd4, 1'b1, 8'h99);
        for (int i = 0; i < 4; i++) begin @(negedge pclk); if (pready2) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_pready got=%0d exp=0", seen); end
        xfer(2, 4'd4, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL abort_no_write got=%h exp=00", rd); end
    endtask

    task automatic test_stray_enable;
        int seen = 0;
        @(negedge pclk); drive(2, 1'b1, 1'b1, 4'd6, 1'b1, 8'h44);
        for (int i = 0; i < 4; i++) begin @(negedge pclk); if (pready2) seen++; end
        drive(2, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        total++; if (seen !== 0) begin bad++; $display("FAIL stray_penable got=%0d exp=0", seen); end
    endtask

    task automatic test_async_reset;
        logic [7:0] rd; logic err, rs; int cyc;
        @(negedge pclk);
        drive(0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
        drive(2, 1'b1, 1'b0, 4'd1, 1'b1, 8'h5A);
        @(negedge pclk);
        drive(0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
        drive(2, 1'b1, 1'b1, 4'd1, 1'b1, 8'h5A);
        total++; if (pready0 !== 1'b1 || prdata0 !== 8'hA5) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/a5", pready0, prdata0); end
        #2 presetn = 1'b0;
        #1;
        total++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 8'h00) begin bad++; $display("FAIL rst_async0 got=%b/%b/%h exp=0/0/00", pready0, pslverr0, prdata0); end
        total++; if (pready2 !== 1'b0 || pslverr2 !== 1'b0 || prdata2 !== 8'h00) begin bad++; $display("FAIL rst_async2 got=%b/%b/%h exp=0/0/00", pready2, pslverr2, prdata2); end
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        @(negedge pclk); presetn = 1'b1;
        xfer(0, 4'd1, 1'b0, 8'h00, rd, err, cyc, rs); idle(0);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL rst_w0_addr1 got=%h exp=00", rd); end
        xfer(2, 4'd1, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL rst_w2_addr1 got=%h exp=00", rd); end
        xfer(2, 4'd7, 1'b1, 8'h42, rd, err, cyc, rs); idle(2);
        xfer(2, 4'd7, 1'b0, 8'h00, rd, err, cyc, rs); idle(2);
        total++; if (cyc !== 3 || rd !== 8'h42 || err !== 1'b0) begin bad++; $display("FAIL rst_after got=%0d/%h/%b exp=3/42/0", cyc, rd, err); end
    endtask

    initial begin
        presetn = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        repeat (3) @(negedge pclk);
        test_reset;
        presetn = 1'b1;
        test_rw_wait2;
        test_id;
        test_out_of_range;
        test_back_to_back;
        test_abort;
        test_stray_enable;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_slave_regfile

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that sits directly downstream of the team's APB master and answers its `psel`/`penable`/`paddr`/`pwrite`/`pwdata` transfers. It contains a small byte-wide register file with a read-only ID register at address 0 and out-of-range error reporting. A programmable number of wait states exercises the master's `pready` hold path. Every output is registered.

## Interface
- `ADDR_W`, 4, address width; must match the master's `paddr`.
- `DATA_W`, 8, data width.
- `DEPTH`, 12, implemented locations 0..DEPTH-1; addresses ≥ DEPTH are errors.
- `WAIT_CYCLES`, 2, access-phase cycles with `pready` low before completion (0..15).
- `ID_VALUE`, 8'hA5, constant returned by reads of address 0.
- `pclk` in 1: single clock; all state changes on its rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `psel` in 1: slave select from the master.
- `penable` in 1: access-phase indicator.
- `paddr` in ADDR_W: transfer address.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in DATA_W: write data.
- `prdata` out DATA_W: read data; valid only while `pready`=1 on a read.
- `pready` out 1: transfer completes at the edge where `psel&penable&pready`.
- `pslverr` out 1: error response; valid only while `pready`=1.

## Operation
- Reset (async): all outputs 0, state IDLE, wait counter 0, latched address/data/direction 0, register file locations 1..DEPTH-1 cleared to 0.
- States: IDLE, WAIT, DONE.
- IDLE: sample `psel=1 && penable=0` (setup phase).
  - On setup: latch `paddr`, `pwrite`, `pwdata`; load counter = WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go to DONE and register `pready=1`.
  - Otherwise go to WAIT.
- WAIT: while `psel&penable`, decrement the counter each cycle.
  - When the counter reaches 1, go to DONE on the next edge and assert `pready`.
  - If `psel` drops, the master has aborted: go to IDLE with no side effects.
- DONE: `pready=1`; `pslverr` and `prdata` come from the latched request.
  - On the completion edge (`psel&penable`), perform the write if legal. Then go to IDLE and clear `pready`, `pslverr` and `prdata` to 0.
  - If `psel` drops in DONE, go to IDLE with no write.
- Error rules:
  - Latched address ≥ DEPTH: `pslverr=1`; a read returns 8'h00 and a write has no effect.
  - Write to address 0: `pslverr=1`, no effect.
  - Read of address 0: `prdata=ID_VALUE`, `pslverr=0`.
- Writes commit only on the completion edge and never in WAIT. The written byte comes from the latched `pwdata`; a write response drives `prdata=0`.
- Back-to-back transfers: after a completion the master re-enters setup on the next cycle; IDLE recognises it without a bubble.
- An unexpected `penable=1` while in IDLE is ignored (no setup seen).
- Reset asserted mid-transfer aborts immediately: no write commits and all outputs go to 0 asynchronously.

## Timing
- Setup cycle S: `psel=1`, `penable=0`. First access cycle is S+1.
- `pready` rises in access cycle S+1+WAIT_CYCLES. Completion is at the end of that cycle, so total transfer = 2+WAIT_CYCLES cycles.
- `prdata` and `pslverr` change in the same cycle as `pready`, both registered; there is no combinational path from inputs to outputs.
- `pready` is high for exactly one cycle per completed transfer.

## Structure
- Shared package `apb_pkg`:
  - state enum (IDLE/WAIT/DONE);
  - default `ADDR_W`/`DATA_W`;
  - `ID_VALUE` constant.
  - The master reuses the width constants from this package.
- One sub-module, `apb_regfile_mem`: DEPTH×DATA_W storage with synchronous write-enable, asynchronous read and async clear. The FSM, wait counter and error decode stay in the top.

## Test plan
- WAIT_CYCLES=2: write 8'h3C to addr 5, then read addr 5 → `pready` high in the 3rd access cycle of each transfer (4 cycles per transfer); read returns 8'h3C with `pslverr=0`.
- Read addr 0 → `prdata=8'hA5`. Write 8'hFF to addr 0 → `pslverr=1`; a following read still returns 8'hA5.
- Read addr 13 → `pslverr=1`, `prdata=8'h00`. Write 8'h77 to addr 14 → `pslverr=1`, and no location 1..11 changes.
- WAIT_CYCLES=0 back-to-back writes to addrs 1, 2, 3 (values 11/22/33), then reads → each transfer takes 2 cycles with no bubble; readback is 8'h11, 8'h22, 8'h33.
- Drop `psel` in the middle of the WAIT of a write of 8'h99 to addr 4 → no `pready`; addr 4 still reads 8'h00.
- Assert `presetn=0` mid-WAIT and off a clock edge → `pready`, `pslverr` and `prdata` go to 0 immediately; after release, addr 1 reads 8'h00 and a new transfer completes normally.
